// File: rtl/sequential_divider_if.sv
// Handshake bundle for sequential_divider: operand request channel and result response channel.
interface sequential_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Restoring divider, one quotient bit per clock; result WIDTH cycles after accept (1 for /0), one op in flight,
// in_ready low from accept until the result handshakes. SEQ_DIVIDER_SIGNED_EN selects two's complement operands.
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sequential_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    mag_a     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    mag_b     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    mag_a     = bus.dividend;
    mag_b     = bus.divisor;
`endif
    // The shifted partial remainder needs WIDTH+1 bits before the compare.
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    rem_next  = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
    dvd_next  = {dvd_q[WIDTH-2:0], q_bit};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          dvs_d   = mag_b;
          // A zero divisor keeps the raw dividend so it can be returned as the remainder.
          dvd_d   = (bus.divisor == '0) ? bus.dividend : mag_a;
`ifdef SEQ_DIVIDER_SIGNED_EN
          qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d  = bus.dividend[WIDTH-1];
`endif
        end
      end
      BUSY: begin
        if (dvs_q == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rmd_d   = dvd_q;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            quo_d   = qneg_q ? -dvd_next : dvd_next;
            rmd_d   = rneg_q ? -rem_next : rem_next;
`else
            quo_d   = dvd_next;
            rmd_d   = rem_next;
`endif
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider (WIDTH=8): directed vectors, expected results queued at issue.
module tb_sequential_divider;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t expq[$];

  sequential_divider_if #(.WIDTH(W)) dif ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed whenever valid and ready meet at the coming edge.
  always @(negedge clk) begin
    if (!rst && dif.out_valid && dif.out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("quotient", {24'd0, dif.quotient}, {24'd0, e.q});
        check("remainder", {24'd0, dif.remainder}, {24'd0, e.r});
        check("div_by_zero", {31'd0, dif.div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz, input logic push);
    int n;
    exp_t e;
    n = 0;
    while (!dif.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!dif.in_ready) check("issue_timeout", 32'd0, 32'd1);
    dif.in_valid = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
  endtask

  // Called right after the accept edge; counts cycles to out_valid and checks in_ready stays low.
  task automatic wait_out(input int exp_lat);
    int  n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (!dif.out_valid && n < 50) begin
      if (dif.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (dif.in_ready) busy_ok = 1'b0;
    check("latency", n, exp_lat);
    check("in_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int lat);
    issue(a, b, eq, er, edbz, 1'b1);
    wait_out(lat);
    @(posedge clk); #1;
    check("in_ready_after_handshake", {31'd0, dif.in_ready}, 32'd1);
    check("out_valid_after_handshake", {31'd0, dif.out_valid}, 32'd0);
  endtask

  logic [W-1:0] hold_q;
  logic [W-1:0] hold_r;
  logic         quiet_ok;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
    check("rst_quotient", {24'd0, dif.quotient}, 32'd0);
    check("rst_remainder", {24'd0, dif.remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, dif.div_by_zero}, 32'd0);

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 8);
    run_op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1);
    run_op(8'd5, 8'd5, 8'd1, 8'd0, 1'b0, 8);
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
    run_op(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 8);
    run_op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 8);
    run_op(8'hF9, 8'd0, 8'hFF, 8'hF9, 1'b1, 1);
    hold_q = 8'hFA;
    hold_r = 8'hFE;
`else
    run_op(8'd250, 8'd16, 8'd15, 8'd10, 1'b0, 8);
    run_op(8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 8);
    run_op(8'd128, 8'd255, 8'd0, 8'd128, 1'b0, 8);
    hold_q = 8'd22;
    hold_r = 8'd2;
`endif

    // Result held under backpressure; in_valid during DONE must be ignored.
    dif.out_ready = 1'b0;
    issue(8'd200, 8'd9, hold_q, hold_r, 1'b0, 1'b1);
    wait_out(8);
    for (int i = 0; i < 5; i++) begin
      dif.in_valid = 1'b1;
      dif.dividend = 8'd1;
      dif.divisor  = 8'd1;
      check("hold_quotient", {24'd0, dif.quotient}, {24'd0, hold_q});
      check("hold_remainder", {24'd0, dif.remainder}, {24'd0, hold_r});
      check("hold_out_valid", {31'd0, dif.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, dif.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("release_out_valid", {31'd0, dif.out_valid}, 32'd0);

    // Reset in the middle of an operation discards it.
    issue(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, dif.in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, dif.out_valid}, 32'd0);
    check("midrst_quotient", {24'd0, dif.quotient}, 32'd0);
    check("midrst_remainder", {24'd0, dif.remainder}, 32'd0);
    check("midrst_div_by_zero", {31'd0, dif.div_by_zero}, 32'd0);
    quiet_ok = 1'b1;
    repeat (12) begin
      if (dif.out_valid || !dif.in_ready) quiet_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("midrst_no_stale_result", {31'd0, quiet_ok}, 32'd1);

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);

    check("scoreboard_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
